// File: rtl/uart_word_tx_if.sv
// ============================================================================
// Module   : uart_word_tx_if
// Purpose  : Word handshake plus UART line/status bundle for uart_word_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_word_tx_if;
    logic        word_valid;
    logic [31:0] word_in;
    logic        word_ready;
    logic        tx_serial;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  byte_index;

    modport master (
        output word_valid,
        output word_in,
        input  word_ready,
        input  tx_serial,
        input  tx_busy,
        input  tx_done,
        input  byte_index
    );

    modport slave (
        input  word_valid,
        input  word_in,
        output word_ready,
        output tx_serial,
        output tx_busy,
        output tx_done,
        output byte_index
    );
endinterface

`default_nettype wire

// File: rtl/uart_word_tx.sv
// ============================================================================
// Module   : uart_word_tx
// Purpose  : Serializes a 32-bit word as four little-endian 8N1 UART bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_word_tx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  wire logic      clk,
    input  wire logic      reset,
    uart_word_tx_if.slave  bus
);

    localparam int              c_BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    logic [1:0]      r_state;
    logic [c_BW-1:0] r_baud;
    logic [2:0]      r_bit;
    logic [1:0]      r_idx;
    logic [31:0]     r_shift;
    logic            r_serial;
    logic            r_busy;
    logic            r_done;

    logic [1:0]      w_state_nxt;
    logic [c_BW-1:0] w_baud_nxt;
    logic [2:0]      w_bit_nxt;
    logic [1:0]      w_idx_nxt;
    logic [31:0]     w_shift_nxt;
    logic            w_serial_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_tick;

    assign w_tick = (r_baud == c_BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_serial <= w_serial_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // The shift register drops one bit per data bit, so the byte on the line
    // is always r_shift[7:0] and the next byte slides down automatically.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        case (r_state)
            c_S_IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                w_idx_nxt  = '0;
                if (bus.word_valid) begin
                    w_shift_nxt = bus.word_in;
                    w_state_nxt = c_S_START;
                end
            end
            c_S_START: begin
                if (w_tick) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = c_S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            c_S_DATA: begin
                if (w_tick) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[31:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = c_S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                if (w_tick) begin
                    w_baud_nxt = '0;
                    if (r_idx == 2'd3) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = c_S_START;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so the line
    // level always lines up with the state it belongs to.
    always_comb begin
        w_serial_nxt = 1'b1;
        w_busy_nxt   = (w_state_nxt != c_S_IDLE);
        w_done_nxt   = (r_state == c_S_STOP) && (w_state_nxt == c_S_IDLE);
        case (w_state_nxt)
            c_S_START: w_serial_nxt = 1'b0;
            c_S_DATA:  w_serial_nxt = w_shift_nxt[0];
            default:   w_serial_nxt = 1'b1;
        endcase
    end

    assign bus.word_ready = (r_state == c_S_IDLE);
    assign bus.tx_serial  = r_serial;
    assign bus.tx_busy    = r_busy;
    assign bus.tx_done    = r_done;
    assign bus.byte_index = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_tx.sv
// ============================================================================
// Module   : tb_uart_word_tx
// Purpose  : Self-checking bench for uart_word_tx at CLKS_PER_BIT 4 and 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_word_tx;

    localparam int CPB_A = 4;
    localparam int CPB_B = 2;

    localparam int MODE_PLAIN   = 0;
    localparam int MODE_HOLD    = 1;
    localparam int MODE_INTRUDE = 2;
    localparam int MODE_RESET   = 3;
    localparam int MODE_SCRAMB  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_r = 1'b0;
    logic [31:0] win_r = '0;
    int          sel = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    uart_word_tx_if ifa ();
    uart_word_tx_if ifb ();

    assign ifa.word_valid = (sel == 0) && valid_r;
    assign ifb.word_valid = (sel == 1) && valid_r;
    assign ifa.word_in    = win_r;
    assign ifb.word_in    = win_r;

    uart_word_tx #(.CLKS_PER_BIT(CPB_A)) u_dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    uart_word_tx #(.CLKS_PER_BIT(CPB_B)) u_dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    // {tx_serial, tx_busy, word_ready, tx_done, byte_index}
    logic [5:0] obs;
    assign obs = (sel == 1)
        ? {ifb.tx_serial, ifb.tx_busy, ifb.word_ready, ifb.tx_done, ifb.byte_index}
        : {ifa.tx_serial, ifa.tx_busy, ifa.word_ready, ifa.tx_done, ifa.byte_index};

    localparam logic [5:0] EXP_IDLE = 6'b101000;
    localparam logic [5:0] EXP_DONE = 6'b101100;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_vec++;
        assert (o === e) else begin
            n_miss++;
            $error("FAIL %s (dut %0d): observed %0h expected %0h", tag, sel, o, e);
        end
    endtask

    // Line level of frame bit n of a word: 10 bits per byte, start/data/stop.
    function automatic logic fbit(input logic [31:0] w, input int n);
        int b;
        int p;
        b = n / 10;
        p = n % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return w[b*8 + p - 1];
    endfunction

    // Called at a negedge where the DUT is idle; returns at the tx_done negedge
    // (or one cycle after recovery when the frame is aborted by reset).
    task automatic frame(input logic [31:0] w, input int mode, output bit aborted);
        int         cpb;
        int         n;
        logic [1:0] idx;
        aborted = 1'b0;
        cpb = (sel == 1) ? CPB_B : CPB_A;
        chk("ready_before_accept", {31'd0, obs[3]}, 32'd1);
        valid_r = 1'b1;
        win_r   = w;
        @(negedge clk);
        if (mode != MODE_HOLD) valid_r = 1'b0;
        for (int k = 0; k < 40*cpb; k++) begin
            n   = k / cpb;
            idx = 2'(n / 10);
            chk($sformatf("frame_w%08h_k%0d", w, k), {26'd0, obs},
                {26'd0, fbit(w, n), 1'b1, 1'b0, 1'b0, idx});
            if (mode == MODE_INTRUDE) begin
                valid_r = (n >= 12) && (n < 15);
                win_r   = 32'hDEAD_BEEF;
            end
            if (mode == MODE_SCRAMB) win_r = $urandom;
            if (mode == MODE_RESET && k == 24*cpb + 1) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("after_reset", {26'd0, obs}, {26'd0, EXP_IDLE});
                @(negedge clk);
                chk("no_done_after_reset", {26'd0, obs}, {26'd0, EXP_IDLE});
                aborted = 1'b1;
                return;
            end
            @(negedge clk);
        end
        chk($sformatf("done_w%08h", w), {26'd0, obs}, {26'd0, EXP_DONE});
    endtask

    task automatic idle_cycles(input int cnt);
        valid_r = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            chk("idle_after_frame", {26'd0, obs}, {26'd0, EXP_IDLE});
        end
    endtask

    initial begin
        bit ab;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sel = 0;
        chk("reset_state_a", {26'd0, obs}, {26'd0, EXP_IDLE});
        sel = 1;
        chk("reset_state_b", {26'd0, obs}, {26'd0, EXP_IDLE});

        sel = 0;
        frame(32'h1234_5678, MODE_PLAIN, ab);
        idle_cycles(2);

        frame(32'hFFFF_FFFF, MODE_HOLD, ab);
        frame(32'h0000_0000, MODE_PLAIN, ab);
        idle_cycles(2);

        frame($urandom, MODE_INTRUDE, ab);
        idle_cycles(3);

        frame($urandom, MODE_RESET, ab);
        chk("reset_aborted", {31'd0, ab}, 32'd1);
        frame(32'hA5A5_A5A5, MODE_PLAIN, ab);
        idle_cycles(2);

        frame(32'h0F0F_0F0F, MODE_SCRAMB, ab);
        idle_cycles(2);

        for (int i = 0; i < 3; i++) begin
            frame($urandom, MODE_PLAIN, ab);
            idle_cycles(1 + (i % 2));
        end

        sel = 1;
        frame(32'h1234_5678, MODE_PLAIN, ab);
        idle_cycles(1);
        for (int i = 0; i < 3; i++) begin
            frame($urandom, MODE_HOLD, ab);
        end
        frame($urandom, MODE_PLAIN, ab);
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
